legv8_multicycle_ctrl: RTL

Parametrised multi-cycle control unit for the LEGv8 datapath. It supersedes the single-cycle combinational decoder. The block sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with instruction and data memories. It decodes the 11-bit opcode by prefix class, detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/legv8_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// prefix-class opcode decode, memory-wait timeouts, a sticky trap and a retire counter.
module legv8_multicycle_ctrl #(
    parameter int OPC_W   = 11,
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               alu_zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               pc_write,
    output logic               pc_src,
    output logic               ir_write,
    output logic               reg2loc,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_ILLEGAL, C_B, C_CBZ, C_CBNZ, C_ALU, C_LDUR, C_STUR} class_t;

    state_t             state_reg, state_next;
    class_t             cls;
    logic [OPC_W-1:0]   opcode_reg;
    logic [7:0]         wait_reg, wait_next;
    logic [CNT_W-1:0]   retired_reg;
    logic               trap_reg;
    logic [1:0]         cause_reg, cause_next;
    logic               retire_now, waiting, is_branch, taken;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_alu_src, dec_reg2loc;
    logic [5:0]         pfx6;
    logic [7:0]         pfx8;
    logic [9:0]         pfx10;
    logic [10:0]        pfx11;

    assign pfx6  = opcode_reg[OPC_W-1 -: 6];
    assign pfx8  = opcode_reg[OPC_W-1 -: 8];
    assign pfx10 = opcode_reg[OPC_W-1 -: 10];
    assign pfx11 = opcode_reg[OPC_W-1 -: 11];

    // Shorter prefixes win, so branch classes are recognised before the full-width table.
    always_comb begin
        cls         = C_ILLEGAL;
        dec_alu_op  = '0;
        dec_alu_src = 1'b0;
        dec_reg2loc = 1'b0;
        if (pfx6 == 6'b000101) begin
            cls = C_B;    dec_alu_op = ALUOP_W'(8); dec_reg2loc = 1'b1;
        end else if (pfx8 == 8'b10110100) begin
            cls = C_CBZ;  dec_alu_op = ALUOP_W'(7); dec_reg2loc = 1'b1;
        end else if (pfx8 == 8'b10110101) begin
            cls = C_CBNZ; dec_alu_op = ALUOP_W'(9); dec_reg2loc = 1'b1;
        end else if (pfx10 == 10'b1001000100) begin
            cls = C_ALU;  dec_alu_op = ALUOP_W'(2); dec_alu_src = 1'b1;
        end else if (pfx10 == 10'b1101000100) begin
            cls = C_ALU;  dec_alu_op = ALUOP_W'(6); dec_alu_src = 1'b1;
        end else begin
            case (pfx11)
                11'b10001010000: begin cls = C_ALU; dec_alu_op = ALUOP_W'(0); end
                11'b10001011000: begin cls = C_ALU; dec_alu_op = ALUOP_W'(2); end
                11'b10101010000: begin cls = C_ALU; dec_alu_op = ALUOP_W'(1); end
                11'b11001011000: begin cls = C_ALU; dec_alu_op = ALUOP_W'(6); end
                11'b11111000000: begin
                    cls = C_STUR; dec_alu_op = ALUOP_W'(2); dec_alu_src = 1'b1; dec_reg2loc = 1'b1;
                end
                11'b11111000010: begin
                    cls = C_LDUR; dec_alu_op = ALUOP_W'(2); dec_alu_src = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign is_branch = (cls == C_B) || (cls == C_CBZ) || (cls == C_CBNZ);
    assign taken     = (cls == C_B) || ((cls == C_CBZ) && alu_zero) || ((cls == C_CBNZ) && !alu_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            opcode_reg  <= '0;
            wait_reg    <= '0;
            retired_reg <= '0;
            trap_reg    <= 1'b0;
            cause_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            cause_reg <= cause_next;
            if (state_reg == S_FETCH && imem_ready)
                opcode_reg <= opcode;
            if (retire_now)
                retired_reg <= retired_reg + 1'b1;
            if (state_next == S_TRAP)
                trap_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        retire_now = 1'b0;
        waiting    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (imem_ready) begin
                    state_next = S_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wait_reg == 8'(TIMEOUT - 1)) begin
                        state_next = S_TRAP;
                        cause_next = 2'd2;
                    end
                end
            end
            S_DECODE: begin
                if (cls == C_ILLEGAL) begin
                    state_next = S_TRAP;
                    cause_next = 2'd1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    retire_now = 1'b1;
                    state_next = S_FETCH;
                end else if (cls == C_LDUR || cls == C_STUR) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (cls == C_STUR) begin
                        retire_now = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_reg == 8'(TIMEOUT - 1)) begin
                        state_next = S_TRAP;
                        cause_next = 2'd3;
                    end
                end
            end
            S_WB: begin
                retire_now = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP:  ;
            default: state_next = S_FETCH;
        endcase
        if (state_next != state_reg)
            wait_next = '0;
        else if (waiting)
            wait_next = wait_reg + 8'd1;
        else
            wait_next = wait_reg;
    end

    // Fetch and branch strobes are qualified by ready/zero so each handshake closes in its own cycle.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg2loc    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        reg_write  = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                end
                S_EXEC: begin
                    alu_op   = dec_alu_op;
                    alu_src  = dec_alu_src;
                    reg2loc  = dec_reg2loc;
                    branch   = is_branch;
                    pc_write = is_branch && taken;
                    pc_src   = is_branch && taken;
                end
                S_MEM: begin
                    alu_op    = dec_alu_op;
                    alu_src   = dec_alu_src;
                    reg2loc   = dec_reg2loc;
                    mem_read  = (cls == C_LDUR);
                    mem_write = (cls == C_STUR);
                end
                S_WB: begin
                    alu_op     = dec_alu_op;
                    alu_src    = dec_alu_src;
                    reg2loc    = dec_reg2loc;
                    reg_write  = 1'b1;
                    mem_to_reg = (cls == C_LDUR);
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_reg;
    assign trap_cause = cause_reg;
    assign retired    = retired_reg;

endmodule
